instr_fetch_unit: RTL and testbench

Initiator side of the instruction-memory strobe/ack interface: owns the PC, issues one word-fetch request per cycle, and presents fetched instructions with their PC to the decode stage. Sits between the instruction memory (fixed 1-cycle read latency, no backpressure) and decode. Absorbs decode stalls in a 2-entry buffer and discards in-flight fetches on a PC redirect from execute.

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_checker.sv | 14 +
 rtl/instr_fetch_unit_skid_buffer.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
package instr_fetch_unit_pkg;

  // Canonical NOP (addi x0, x0, 0); decode injects it as a bubble.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_checker.sv
// Protocol checker: memory must only acknowledge a request that is in flight.
module fetch_protocol_checker (
  input logic i_clk,
  input logic i_rst,
  input logic i_ack,
  input logic inflight
);

  // An ack with no outstanding request means the memory side misbehaved.
  ack_needs_request_a : assert property (
    @(posedge i_clk) disable iff (i_rst) i_ack |-> inflight
  );

endmodule

// File: rtl/instr_fetch_unit_skid_buffer.sv
// Two-entry FIFO holding fetched instructions while decode stalls.
// Flush wins over push and pop; push and pop together keep count steady.
module fetch_skid_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Entry storage; data needs no reset because count gates its use.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush && !i_rst) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointer and occupancy tracking with reset and flush clearing them.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (i_push) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (i_pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({i_push, i_pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one word fetch per cycle to a
// 1-cycle-latency memory, and buffers responses for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 8192,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  localparam int         ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_stb,
  input  logic              i_ack,
  input  logic [31:0]       i_instr,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  input  logic              i_stall,
  input  logic              i_change_pc,
  input  logic [31:0]       i_new_pc
);

  logic [31:0]  pc_r;
  logic [31:0]  fetch_pc_r;
  logic         inflight_r;
  logic [1:0]   count_s;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;
  logic         pop_s;
  logic         push_s;
  logic [2:0]   occupancy_s;

  assign o_valid     = (count_s != 2'd0);
  assign pop_s       = o_valid & ~i_stall;
  // Acks are only meaningful for a request we actually issued; a redirect
  // drops whatever arrives in its cycle.
  assign push_s      = i_ack & inflight_r & ~i_change_pc;
  assign push_data_s = '{pc: fetch_pc_r, instr: i_instr};
  // Slots that will be spoken for after this cycle; pop never exceeds count.
  assign occupancy_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Issue a fetch only when the response is guaranteed a buffer slot.
  always_comb begin
    o_stb = 1'b0;
    if (!i_rst && !i_change_pc && (occupancy_s < 3'd2)) begin
      o_stb = 1'b1;
    end else begin
      o_stb = 1'b0;
    end
  end

  // PC sequencing and in-flight tracking; redirect overrides issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_r       <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      inflight_r <= 1'b0;
    end else if (i_change_pc) begin
      pc_r       <= i_new_pc & ~32'h0000_0003;
      inflight_r <= 1'b0;
    end else if (o_stb) begin
      fetch_pc_r <= pc_r;
      pc_r       <= pc_r + 32'd4;
      inflight_r <= 1'b1;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  assign o_addr  = pc_r[ADDR_W+1:2];
  assign o_instr = head_s.instr;
  assign o_pc    = head_s.pc;

  fetch_skid_buffer u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_flush (i_change_pc),
    .i_data  (push_data_s),
    .count   (count_s),
    .head    (head_s)
  );

  fetch_protocol_checker u_checker (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ack    (i_ack),
    .inflight (inflight_r)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, instr} streams are
// queued whenever fetch is (re)started; a negedge monitor pops on every
// decode handshake and compares.
module tb_instr_fetch_unit;

  localparam int DEPTH  = 8192;
  localparam int ADDR_W = 13;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [ADDR_W-1:0] o_addr;
  logic              o_stb;
  logic              i_ack;
  logic [31:0]       i_instr;
  logic              o_valid;
  logic [31:0]       o_instr;
  logic [31:0]       o_pc;
  logic              i_stall;
  logic              i_change_pc;
  logic [31:0]       i_new_pc;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  logic [ADDR_W-1:0] mem_addr_q;

  always #5 i_clk = ~i_clk;

  instr_fetch_unit #(.MEMORY_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_addr      (o_addr),
    .o_stb       (o_stb),
    .i_ack       (i_ack),
    .i_instr     (i_instr),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .i_stall     (i_stall),
    .i_change_pc (i_change_pc),
    .i_new_pc    (i_new_pc)
  );

  // Memory: word k holds 0x1000_0000 + k, one-cycle read latency.
  always @(posedge i_clk) begin
    i_ack      <= o_stb;
    mem_addr_q <= o_addr;
  end
  assign i_instr = 32'h1000_0000 + {19'b0, mem_addr_q};

  // Reference: the instruction at byte PC p is the memory word (p/4) mod DEPTH.
  function automatic logic [31:0] word_at(logic [31:0] p);
    return 32'h1000_0000 + ((p >> 2) % 32'(DEPTH));
  endfunction

  // After reset/redirect decode must see consecutive PCs from the start.
  task automatic load_expect(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 450; i++) begin
      exp_q.push_back('{pc: p, instr: word_at(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge i_clk) begin
    if (!i_rst && !i_change_pc && o_valid && !i_stall) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual_pc=%h expected=none", o_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", o_pc, e.pc);
        check("sb_instr", o_instr, e.instr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Redirect in cycle t (caller is just after the edge starting t).
  task automatic do_redirect(input logic [31:0] target);
    logic [31:0] aligned;
    logic [31:0] nxt;
    aligned     = target & ~32'h3;
    nxt         = aligned + 32'd4;
    i_change_pc = 1'b1;
    i_new_pc    = target;
    load_expect(aligned);
    @(negedge i_clk);
    check("redir_stb_t", {31'b0, o_stb}, 32'd0);
    next_cycle();
    i_change_pc = 1'b0;
    i_stall     = 1'b0;
    i_new_pc    = $urandom;
    @(negedge i_clk);
    check("redir_valid_t1", {31'b0, o_valid}, 32'd0);
    check("redir_addr_t1", {19'b0, o_addr}, {19'b0, aligned[ADDR_W+1:2]});
    check("redir_stb_t1", {31'b0, o_stb}, 32'd1);
    @(negedge i_clk);
    check("redir_valid_t2", {31'b0, o_valid}, 32'd0);
    check("redir_addr_t2", {19'b0, o_addr}, {19'b0, nxt[ADDR_W+1:2]});
    @(negedge i_clk);
    check("redir_valid_t3", {31'b0, o_valid}, 32'd1);
    check("redir_pc_t3", o_pc, aligned);
  endtask

  task automatic reset_restart_checks();
    @(negedge i_clk);
    check("rst_c0_valid", {31'b0, o_valid}, 32'd0);
    check("rst_c0_stb", {31'b0, o_stb}, 32'd1);
    @(negedge i_clk);
    check("rst_c1_valid", {31'b0, o_valid}, 32'd0);
    @(negedge i_clk);
    check("rst_c2_valid", {31'b0, o_valid}, 32'd1);
    check("rst_c2_pc", o_pc, 32'h0000_0000);
  endtask

  initial begin
    int p0;
    i_rst       = 1'b1;
    i_stall     = 1'b0;
    i_change_pc = 1'b0;
    i_new_pc    = 32'h0;
    load_expect(32'h0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_stb", {31'b0, o_stb}, 32'd0);
    check("reset_valid", {31'b0, o_valid}, 32'd0);
    check("reset_addr", {19'b0, o_addr}, 32'd0);

    // Cold start then free run.
    next_cycle();
    i_rst = 1'b0;
    reset_restart_checks();
    next_cycle();
    p0 = pops;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      check("run_stb", {31'b0, o_stb}, 32'd1);
    end
    next_cycle();
    check("run_throughput", 32'(pops - p0), 32'd20);

    // Five-cycle stall.
    i_stall = 1'b1;
    p0 = pops;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (k >= 2) check("stall_stb_low", {31'b0, o_stb}, 32'd0);
    end
    check("stall_valid_held", {31'b0, o_valid}, 32'd1);
    next_cycle();
    check("stall_no_pop", 32'(pops - p0), 32'd0);
    i_stall = 1'b0;
    p0 = pops;
    @(negedge i_clk);
    check("release_stb", {31'b0, o_stb}, 32'd1);
    repeat (9) @(negedge i_clk);
    next_cycle();
    check("release_throughput", 32'(pops - p0), 32'd10);

    // Plain redirect.
    repeat (3) next_cycle();
    do_redirect(32'h0000_0103);

    // Redirect while stalled with a full buffer.
    next_cycle();
    repeat (3) next_cycle();
    i_stall = 1'b1;
    repeat (4) next_cycle();
    do_redirect(32'h0000_2203);

    // Wrap of the word address at the top of memory.
    next_cycle();
    repeat (2) next_cycle();
    do_redirect(32'(4 * (DEPTH - 1)));
    @(negedge i_clk);
    check("wrap_pc", o_pc, 32'(4 * DEPTH));
    check("wrap_instr", o_instr, 32'h1000_0000);

    // One-cycle reset with a fetch in flight.
    repeat (5) next_cycle();
    i_rst = 1'b1;
    load_expect(32'h0);
    @(negedge i_clk);
    check("midrst_stb", {31'b0, o_stb}, 32'd0);
    next_cycle();
    i_rst = 1'b0;
    reset_restart_checks();

    // Random stalls, redirects and resets.
    for (int c = 0; c < 600; c++) begin
      int r;
      next_cycle();
      i_rst       = 1'b0;
      i_change_pc = 1'b0;
      r = $urandom_range(0, 99);
      i_stall = ($urandom_range(0, 2) == 0);
      if (r < 2) begin
        i_rst = 1'b1;
        load_expect(32'h0);
      end else if (r < 6) begin
        i_change_pc = 1'b1;
        i_new_pc    = $urandom;
        load_expect(i_new_pc & ~32'h3);
      end
    end
    next_cycle();
    i_rst       = 1'b0;
    i_change_pc = 1'b0;
    i_stall     = 1'b0;
    repeat (5) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
